// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two requesters share one 4-bit signed add/sub unit.
// Results return over valid/ready with owner ID and a saturating overflow count.
module addsub_4bit (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_sub,
   output logic [3:0] o_sum,
   output logic       o_ovfl
);
   logic [3:0] w_b_eff;

   // Subtraction is A + ~B + 1; carry-out falls off the 4-bit add.
   assign w_b_eff = i_sub ? ~i_b : i_b;
   assign o_sum   = i_a + w_b_eff + {3'b000, i_sub};
   assign o_ovfl  = (i_a[3] == w_b_eff[3]) && (o_sum[3] != i_a[3]);
endmodule

module addsub_arbiter #(
   parameter bit RR_EN = 1'b1,
   parameter int OVF_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic             req1_sub,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [3:0]       res_sum,
   output logic             res_ovfl,
   output logic             res_id,
   output logic [OVF_W-1:0] ovfl_cnt
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_last;
   logic [3:0]       r_a;
   logic [3:0]       r_b;
   logic             r_sub;
   logic             r_id;
   logic [3:0]       r_sum;
   logic             r_ovfl;
   logic             r_res_id;
   logic [OVF_W-1:0] r_ovfl_cnt;

   logic       w_open;
   logic       w_g0;
   logic       w_g1;
   logic       w_grant;
   logic [3:0] w_sum;
   logic       w_ovfl;
   logic       w_res_hs;
   logic       w_cnt_max;

   addsub_4bit u_addsub (
      .i_a    (r_a),
      .i_b    (r_b),
      .i_sub  (r_sub),
      .o_sum  (w_sum),
      .o_ovfl (w_ovfl)
   );

   // Readies are gated by rst_n so every output reads 0 in reset.
   always_comb begin
      w_open = rst_n && ((r_state == S_IDLE) ||
                         ((r_state == S_VALID) && res_ready));
      w_g0 = 1'b0;
      w_g1 = 1'b0;
      if (w_open) begin
         if (req0_valid && req1_valid) begin
            if (RR_EN && (r_last == 1'b0)) begin
               w_g1 = 1'b1;
            end else begin
               w_g0 = 1'b1;
            end
         end else if (req0_valid) begin
            w_g0 = 1'b1;
         end else if (req1_valid) begin
            w_g1 = 1'b1;
         end
      end
   end

   assign w_grant    = w_g0 | w_g1;
   assign req0_ready = w_g0;
   assign req1_ready = w_g1;
   assign w_res_hs   = (r_state == S_VALID) && res_ready;
   assign w_cnt_max  = &r_ovfl_cnt;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            w_state_nxt = S_VALID;
         end
         S_VALID: begin
            if (res_ready) begin
               w_state_nxt = w_grant ? S_EXEC : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
         r_a    <= 4'd0;
         r_b    <= 4'd0;
         r_sub  <= 1'b0;
         r_id   <= 1'b0;
      end else if (w_grant) begin
         r_last <= w_g1;
         r_a    <= w_g1 ? req1_a : req0_a;
         r_b    <= w_g1 ? req1_b : req0_b;
         r_sub  <= w_g1 ? req1_sub : req0_sub;
         r_id   <= w_g1;
      end
   end

   // Result register only loads out of EXEC, so it holds through stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum    <= 4'd0;
         r_ovfl   <= 1'b0;
         r_res_id <= 1'b0;
      end else if (r_state == S_EXEC) begin
         r_sum    <= w_sum;
         r_ovfl   <= w_ovfl;
         r_res_id <= r_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovfl_cnt <= '0;
      end else if (w_res_hs && r_ovfl && !w_cnt_max) begin
         r_ovfl_cnt <= r_ovfl_cnt + OVF_W'(1);
      end
   end

   assign res_valid = (r_state == S_VALID);
   assign res_sum   = r_sum;
   assign res_ovfl  = r_ovfl;
   assign res_id    = r_res_id;
   assign ovfl_cnt  = r_ovfl_cnt;
endmodule
